// File: rtl/min_max_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// min_max_pkg : shared state encoding and default sizing for min_max_frame_ctrl
// Revision    : 1.0
// ============================================================================
package min_max_pkg;

  localparam int DEF_DATA_W    = 4;
  localparam int DEF_FRAME_LEN = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    CMP_MIN = 3'd2,
    CMP_MAX = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/min_max_frame_ctrl_mag_comp.sv
`default_nettype none
// ============================================================================
// mag_comp : unsigned combinational magnitude comparator
// Revision : 1.0
// ============================================================================
module mag_comp #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              a_less_b_o,
  output logic              a_great_b_o,
  output logic              a_equal_b_o
);

  assign a_less_b_o  = (a_i <  b_i);
  assign a_great_b_o = (a_i >  b_i);
  assign a_equal_b_o = (a_i == b_i);

endmodule
`default_nettype wire

// File: rtl/min_max_frame_ctrl.sv
`default_nettype none
// ============================================================================
// min_max_frame_ctrl : frame min/max with first-occurrence indices, one shared comparator
// Revision           : 1.0
// ============================================================================
module min_max_frame_ctrl
  import min_max_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int FRAME_LEN = DEF_FRAME_LEN,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_min_idx,
  output logic [IDX_W-1:0]  out_max_idx,
  output logic              busy
);

  localparam logic [IDX_W:0] C_LAST = (IDX_W+1)'(FRAME_LEN - 1);

  state_e              state_q;
  logic [IDX_W:0]      cnt_q;
  logic [DATA_W-1:0]   sample_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   min_q;
  logic [DATA_W-1:0]   max_q;
  logic [IDX_W-1:0]    min_idx_q;
  logic [IDX_W-1:0]    max_idx_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [DATA_W-1:0]   w_cmp_b;
  logic                w_lt;
  logic                w_gt;
  logic                w_eq;
  logic                w_min_upd;
  logic                w_max_upd;

  // One comparator serves both passes; the FSM state selects the reference.
  assign w_cmp_b = (state_q == CMP_MAX) ? max_q : min_q;

  mag_comp #(.DATA_W(DATA_W)) u_cmp (
    .a_i         (sample_q),
    .b_i         (w_cmp_b),
    .a_less_b_o  (w_lt),
    .a_great_b_o (w_gt),
    .a_equal_b_o (w_eq)
  );

  // Ties must never move min/max so the earliest index is kept.
  assign w_min_upd = w_lt & ~w_eq;
  assign w_max_upd = w_gt & ~w_eq;

  assign in_ready    = in_ready_q & ~flush;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sample_q    <= '0;
      idx_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      min_idx_q   <= '0;
      max_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= WAIT_IN;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        WAIT_IN: begin
          if (in_valid && in_ready_q) begin
            if (cnt_q == '0) begin
              min_q     <= in_data;
              max_q     <= in_data;
              min_idx_q <= '0;
              max_idx_q <= '0;
              cnt_q     <= cnt_q + 1'b1;
            end else begin
              sample_q   <= in_data;
              idx_q      <= cnt_q[IDX_W-1:0];
              in_ready_q <= 1'b0;
              state_q    <= CMP_MIN;
            end
          end
        end
        CMP_MIN: begin
          if (w_min_upd) begin
            min_q     <= sample_q;
            min_idx_q <= idx_q;
          end
          state_q <= CMP_MAX;
        end
        CMP_MAX: begin
          if (w_max_upd) begin
            max_q     <= sample_q;
            max_idx_q <= idx_q;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state_q    <= WAIT_IN;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/min_max_frame_ctrl.md
Name: min_max_frame_ctrl

Overview:
- Sequencer that finds the running minimum and maximum, with first-occurrence indices, over a frame of FRAME_LEN unsigned samples.
- Samples arrive on a valid/ready stream; the result leaves on a valid/ready port.
- A single shared combinational magnitude comparator is time-multiplexed: one compare against the current min, then one against the current max, for each sample after the first.
- Sits between a sample source and a consumer of frame statistics.

Parameters:
- DATA_W, 4, sample width in bits, unsigned.
- FRAME_LEN, 8, samples per frame; legal range 2..256.
- IDX_W, $clog2(FRAME_LEN), index/counter width (localparam, derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- flush  in  1  synchronous abort; returns to IDLE from any state.
- in_valid  in  1  sample valid.
- in_data  in  DATA_W  sample.
- in_ready  out  1  controller can accept a sample (high only in WAIT_IN).
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_min  out  DATA_W  frame minimum.
- out_max  out  DATA_W  frame maximum.
- out_min_idx  out  IDX_W  index of first occurrence of the minimum.
- out_max_idx  out  IDX_W  index of first occurrence of the maximum.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state = IDLE.
  - All outputs 0: in_ready, out_valid, busy, out_min, out_max, both indices.
  - Sample register and sample counter cleared.
- States: IDLE, WAIT_IN, CMP_MIN, CMP_MAX, DONE.
- IDLE:
  - start=1 -> WAIT_IN; sample counter cleared.
  - start is ignored in every other state.
- WAIT_IN:
  - in_ready=1; a sample is accepted on in_valid&in_ready.
  - Sample 0: load min=max=in_data, both indices=0, counter=1; stay in WAIT_IN. There is no compare for sample 0.
  - Sample k>0: latch into the sample register with idx=k; -> CMP_MIN.
- CMP_MIN:
  - Comparator A=sample, B=min.
  - If A_less_B: min=sample, min_idx=idx. -> CMP_MAX.
- CMP_MAX:
  - Comparator A=sample, B=max.
  - If A_great_B: max=sample, max_idx=idx. Counter increments.
  - If counter reaches FRAME_LEN -> DONE; otherwise -> WAIT_IN.
- Ties: equality never updates min or max, so indices always report the earliest occurrence.
- Throughput: 1 cycle for sample 0, then 3 cycles per sample. in_ready is low during CMP_MIN and CMP_MAX.
- DONE:
  - out_valid=1; result outputs are registered and stable while out_valid is high.
  - out_valid&out_ready -> IDLE. out_valid is low the following cycle; result registers retain their values.
- flush:
  - Highest priority after reset.
  - Next state IDLE; out_valid never asserts for the aborted frame.
  - An in_data offered in the same cycle is not accepted (in_ready is masked by flush).
- start and flush together in IDLE: flush wins and the controller stays in IDLE.
- Latency from last sample accepted to out_valid: 3 cycles. With in_valid held high and FRAME_LEN=4, out_valid rises 10 cycles after sample 0 is accepted.
- Arithmetic: comparisons are unsigned over DATA_W bits. The counter is IDX_W+1 bits wide so FRAME_LEN is representable.

Decomposition:
- Package min_max_pkg:
  - state enum (IDLE, WAIT_IN, CMP_MIN, CMP_MAX, DONE).
  - Default DATA_W and FRAME_LEN constants.
- Sub-module mag_comp:
  - Parameterised DATA_W, purely combinational.
  - Outputs A_less_B, A_great_B, A_equal_B.
  - Instantiated once; its operand mux is driven by the FSM.

Test Plan (DATA_W=4, FRAME_LEN=4 unless noted):
1. start, frame 3,9,1,9 -> out_min=1, out_min_idx=2, out_max=9, out_max_idx=1 (first occurrence), out_valid=1.
2. Frame 5,5,5,5 -> out_min=out_max=5, both indices 0. Confirms ties never update.
3. in_valid held high from start, frame 7,2,12,4 -> in_ready pattern 1,1,0,0,1,0,0,1,0,0; out_valid rises 10 cycles after sample 0 is accepted; result min=2 idx1, max=12 idx2.
4. out_ready held low 5 cycles in DONE -> out_valid and all results stable, in_ready=0, start pulses ignored; out_ready=1 -> IDLE next cycle, busy=0.
5. flush after 2 samples, then start with frame 15,0,8,7 -> no out_valid for the aborted frame; result min=0 idx1, max=15 idx0.
6. Assert rst mid-CMP_MIN, between clock edges -> in_ready, out_valid, busy, out_min, out_max and indices go to 0 immediately. After release, a start plus a full frame produces a correct result.
